// File: rtl/fir_sample_capture.sv
// Capture stage behind the FIR filter: drops pipeline-fill samples, then buffers settled samples in a FIFO.
// Optional build macro FIR_CAPTURE_PEAK_EN adds a running peak-magnitude tracker on peak_abs.
module fir_sample_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 129
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     settled,
  output logic                     overflow,
  output logic [DATA_W-2:0]        peak_abs
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int unsigned SETTLE_LAST = (SETTLE == 0) ? 0 : SETTLE - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     settle_cnt;
  logic              full;
  logic              push;
  logic              pop;

  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !flush;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = in_valid && settled && !flush && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      settle_cnt <= '0;
      settled    <= 1'b0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      settle_cnt <= '0;
      settled    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (!settled) begin
        if (SETTLE == 0) begin
          settled <= 1'b1;
        end else if (in_valid) begin
          if (settle_cnt == CW'(SETTLE_LAST)) settled <= 1'b1;
          else                                 settle_cnt <= settle_cnt + CW'(1);
        end
      end
      if (in_valid && settled && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: sample storage has no reset; out_data is masked by out_valid so stale contents never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef FIR_CAPTURE_PEAK_EN
  logic [DATA_W-2:0] in_abs;

  // NOTE: every always_comb output gets a value on all paths to avoid an inferred latch.
  always_comb begin
    in_abs = in_data[DATA_W-2:0];
    if (in_data[DATA_W-1]) begin
      if (in_data[DATA_W-2:0] == '0) in_abs = '1;
      else                            in_abs = ~in_data[DATA_W-2:0] + (DATA_W-1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       peak_abs <= '0;
    else if (flush)                     peak_abs <= '0;
    else if (push && in_abs > peak_abs) peak_abs <= in_abs;
  end
`else
  assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_fir_sample_capture.sv
// Bench for fir_sample_capture: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fir_sample_capture;
  localparam int DW     = 16;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 4;
  localparam int LW     = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          settled;
  logic          overflow;
  logic [DW-2:0] peak_abs;

  logic          s0_out_valid;
  logic [DW-1:0] s0_out_data;
  logic [LW-1:0] s0_level;
  logic          s0_settled;
  logic          s0_overflow;
  logic [DW-2:0] s0_peak_abs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_sample_capture #(.DATA_W(DW), .DEPTH(DEPTH), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .settled(settled), .overflow(overflow), .peak_abs(peak_abs)
  );

  fir_sample_capture #(.DATA_W(DW), .DEPTH(DEPTH), .SETTLE(0)) u_s0 (
    .clk(clk), .reset_n(reset_n), .in_valid(1'b0), .in_data('0), .flush(1'b0),
    .out_valid(s0_out_valid), .out_ready(1'b0), .out_data(s0_out_data), .level(s0_level),
    .settled(s0_settled), .overflow(s0_overflow), .peak_abs(s0_peak_abs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of stored samples plus settle/overflow/peak bookkeeping.
  logic [DW-1:0] mq[$];
  int            m_cnt;
  bit            m_settled;
  bit            m_ovf;
  int            m_peak;
  logic [DW-1:0] got[$];
  int            max_level;

  function automatic int abs_sat(input logic [DW-1:0] d);
    int a;
    a = int'($signed(d));
    if (a < 0) a = -a;
    if (a > 2**(DW-1) - 1) a = 2**(DW-1) - 1;
    return a;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit do_pop;
    if (!reset_n || flush) begin
      mq.delete();
      m_cnt     = 0;
      m_settled = 0;
      m_ovf     = 0;
      m_peak    = 0;
    end else begin
      do_pop = (mq.size() > 0) && out_ready;
      if (!m_settled) begin
        if (in_valid) begin
          m_cnt++;
          if (m_cnt == SETTLE) m_settled = 1;
        end
      end else if (in_valid) begin
        if (mq.size() < DEPTH || do_pop) begin
          mq.push_back(in_data);
`ifdef FIR_CAPTURE_PEAK_EN
          if (abs_sat(in_data) > m_peak) m_peak = abs_sat(in_data);
`endif
        end else begin
          m_ovf = 1;
        end
      end
      if (do_pop) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("cyc_out_valid", out_valid, mq.size() != 0);
      check("cyc_level", level, mq.size());
      if (mq.size() != 0) check("cyc_out_data", out_data, mq[0]);
      check("cyc_settled", settled, m_settled);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_peak_abs", peak_abs, m_peak);
      if (out_valid && out_ready && !flush) got.push_back(out_data);
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  task automatic step(input bit iv, input logic [DW-1:0] d, input bit rdy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

`ifdef FIR_CAPTURE_PEAK_EN
  localparam int PK_EXP[4] = '{100, 300, 300, 32767};
`else
  localparam int PK_EXP[4] = '{0, 0, 0, 0};
`endif

  initial begin
    logic [DW-1:0] pk_in[4];
    pk_in = '{16'd100, 16'hFED4, 16'd200, 16'h8000};
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    max_level = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_settled", settled, 0);
    check("rst_overflow", overflow, 0);
    check("rst_peak", peak_abs, 0);
    check("rst_s0_settled", s0_settled, 0);
    reset_n = 1'b1;
    step(0, '0, 0, 0);
    check("s0_settled_first_cycle", s0_settled, 1);
    check("settle_not_yet", settled, 0);

    // Settle discard
    for (int i = 1; i <= 6; i++) begin
      step(1, DW'(i), 0, 0);
      if (i == 4) begin
        check("settle_after_4", settled, 1);
        check("settle_nothing_stored", out_valid, 0);
      end
      if (i == 5) check("settle_first_data", out_data, 5);
    end
    check("settle_level2", level, 2);
    check("settle_hold5", out_data, 5);
    step(0, '0, 1, 0);
    check("settle_second_data", out_data, 6);
    step(0, '0, 1, 0);
    check("settle_empty", out_valid, 0);

    // Backpressure and overflow
    for (int i = 1; i <= 5; i++) step(1, DW'(10 * i), 0, 0);
    check("ovf_level4", level, 4);
    check("ovf_set", overflow, 1);
    check("model_size4", mq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain", out_data, 10 * (k + 1));
      step(0, '0, 1, 0);
    end
    check("ovf_drained_level", level, 0);
    check("ovf_drained_valid", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Flush with level 3
    for (int i = 1; i <= 3; i++) step(1, DW'(i), 0, 0);
    check("flush_pre_level", level, 3);
    step(1, 16'd77, 0, 1);
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_settled", settled, 0);
    check("flush_overflow", overflow, 0);
    for (int i = 8; i <= 11; i++) step(1, DW'(i), 0, 0);
    check("flush_resettled", settled, 1);
    check("flush_discarded", level, 0);

    // Full with simultaneous pop
    for (int i = 11; i <= 14; i++) step(1, DW'(i), 0, 0);
    check("fullpop_level4", level, 4);
    check("fullpop_head11", out_data, 11);
    step(1, 16'd15, 1, 0);
    check("fullpop_level_same", level, 4);
    check("fullpop_no_ovf", overflow, 0);
    for (int k = 0; k < 4; k++) begin
      check("fullpop_drain", out_data, 12 + k);
      step(0, '0, 1, 0);
    end
    check("fullpop_empty", level, 0);

    // Wrap-around streaming
    step(0, '0, 0, 1);
    got.delete();
    max_level = 0;
    for (int i = 0; i < 20; i++) step(1, DW'(i), 1, 0);
    step(0, '0, 1, 0);
    check("wrap_count", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) check("wrap_order", got[k], k + 4);
    check("wrap_max_level_le1", max_level <= 1, 1);
    check("wrap_no_ovf", overflow, 0);

    // Peak tracking
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, pk_in[i], 1, 0);
      check("peak_value", peak_abs, PK_EXP[i]);
    end

    // Asynchronous reset mid-stream
    step(1, 16'd5, 0, 0);
    step(1, 16'd6, 0, 0);
    check("midrst_level_nonzero", level != 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_level", level, 0);
    check("midrst_settled", settled, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_peak", peak_abs, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1, DW'(100 + i), 0, 0);
    check("postrst_head", out_data, 104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
